// File: rtl/sdp_be_bist_if.sv
// Simple dual-port byte-enable RAM bus between the BIST engine (master) and the RAM (slave).
interface sdp_be_bist_if #(
    parameter int WABITS = 10,
    parameter int NBYTES = 4,
    parameter int WDBITS = 32
);
    logic              we;
    logic [NBYTES-1:0] be;
    logic [WABITS-1:0] wa;
    logic [WDBITS-1:0] wd;
    logic [WABITS-1:0] ra;
    logic [WDBITS-1:0] rd;

    modport master (output we, be, wa, wd, ra, input rd);
    modport slave  (input we, be, wa, wd, ra, output rd);
endinterface

// File: rtl/sdp_be_bist.sv
// Byte-enable BIST for a simple dual-port RAM: full-word fill, single-lane inverted
// overwrite, then read-back compare against the merged expected word.
//
// state | meaning
// IDLE  | waiting for start after reset
// FILL  | write P(a) to every word with all byte enables
// MASK  | write ~P(a) into lane a mod NBYTES only
// READ  | issue read addresses, compare returning data
// DRAIN | no new read, last compare still in flight
// DONE  | results held, done asserted
module sdp_be_bist #(
    parameter int WABITS    = 10,
    parameter int BYTEWIDTH = 8,
    parameter int NBYTES    = 4,
    parameter int WDBITS    = NBYTES*BYTEWIDTH,
    parameter int DEPTH     = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    sdp_be_bist_if.master     ram,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [WABITS-1:0] fail_addr,
    output logic [15:0]       err_count
);

    typedef enum logic [2:0] {IDLE, FILL, MASK, READ, DRAIN, DONE} state_t;

    state_t            state;
    logic [WABITS-1:0] cnt;
    logic [WABITS-1:0] cmp_addr;
    logic              rd_issued;
    logic              rd_valid;
    logic              cnt_last;
    logic              go;

    function automatic logic [WDBITS-1:0] pat(input logic [WABITS-1:0] a);
        logic [WDBITS-1:0] p;
        p = '0;
        for (int i = 0; i < NBYTES; i++)
            p[i*BYTEWIDTH +: BYTEWIDTH] = BYTEWIDTH'(a) + BYTEWIDTH'(i);
        return p;
    endfunction

    function automatic logic [NBYTES-1:0] lane(input logic [WABITS-1:0] a);
        logic [NBYTES-1:0] l;
        l = '0;
        for (int i = 0; i < NBYTES; i++)
            l[i] = ((int'(a) % NBYTES) == i);
        return l;
    endfunction

    function automatic logic [WDBITS-1:0] expect_word(input logic [WABITS-1:0] a);
        logic [WDBITS-1:0] e;
        logic [NBYTES-1:0] l;
        e = pat(a);
        l = lane(a);
        for (int i = 0; i < NBYTES; i++)
            if (l[i]) e[i*BYTEWIDTH +: BYTEWIDTH] = ~e[i*BYTEWIDTH +: BYTEWIDTH];
        return e;
    endfunction

    assign cnt_last = (cnt == WABITS'(DEPTH-1));
    // done gates the restart so results are visible for at least one cycle
    assign go = start && (state == IDLE || (state == DONE && done));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            ram.we    <= 1'b0;
            ram.be    <= '0;
            ram.wa    <= '0;
            ram.wd    <= '0;
            ram.ra    <= '0;
            rd_issued <= 1'b0;
            rd_valid  <= 1'b0;
            cmp_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fail      <= 1'b0;
            fail_addr <= '0;
            err_count <= '0;
        end else begin
            ram.we    <= 1'b0;
            ram.be    <= '0;
            rd_issued <= 1'b0;
            rd_valid  <= rd_issued;
            cmp_addr  <= ram.ra;

            // rd now carries the word for the address issued two edges ago
            if (rd_valid && ram.rd != expect_word(cmp_addr)) begin
                if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                if (!fail) fail_addr <= cmp_addr;
                fail <= 1'b1;
            end

            if (go) begin
                state     <= FILL;
                cnt       <= '0;
                busy      <= 1'b1;
                done      <= 1'b0;
                fail      <= 1'b0;
                fail_addr <= '0;
                err_count <= '0;
            end else begin
                unique case (state)
                    IDLE: ;
                    FILL: begin
                        ram.we <= 1'b1;
                        ram.be <= '1;
                        ram.wa <= cnt;
                        ram.wd <= pat(cnt);
                        cnt    <= cnt_last ? '0 : cnt + 1'b1;
                        if (cnt_last) state <= MASK;
                    end
                    MASK: begin
                        ram.we <= 1'b1;
                        ram.be <= lane(cnt);
                        ram.wa <= cnt;
                        ram.wd <= ~pat(cnt);
                        cnt    <= cnt_last ? '0 : cnt + 1'b1;
                        if (cnt_last) state <= READ;
                    end
                    READ: begin
                        ram.ra    <= cnt;
                        rd_issued <= 1'b1;
                        cnt       <= cnt_last ? '0 : cnt + 1'b1;
                        if (cnt_last) state <= DRAIN;
                    end
                    DRAIN: state <= DONE;
                    DONE: begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sdp_be_bist.sv
// Bench for sdp_be_bist against a 16-word byte-enable SDP RAM model with fault modes.
module tb_sdp_be_bist;
    localparam int WABITS = 4, BYTEWIDTH = 8, NBYTES = 4, WDBITS = 32, DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, fail;
    logic [3:0]  fail_addr;
    logic [15:0] err_count;

    sdp_be_bist_if #(.WABITS(WABITS), .NBYTES(NBYTES), .WDBITS(WDBITS)) ram_bus ();

    sdp_be_bist #(.WABITS(WABITS), .BYTEWIDTH(BYTEWIDTH), .NBYTES(NBYTES),
                  .WDBITS(WDBITS), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .ram(ram_bus),
        .busy(busy), .done(done), .fail(fail), .fail_addr(fail_addr), .err_count(err_count)
    );

    always #5 clk = ~clk;

    // ram_mode: 0 clean, 1 bit 9 stuck-at-1 at addr 5, 2 bit 9 stuck-at-0 at addr 5, 3 ignore be
    int          ram_mode = 0;
    logic [31:0] mem [16];
    logic [31:0] rd_q = '0;
    assign ram_bus.rd = rd_q;

    always @(posedge clk) begin
        logic [31:0] w;
        if (ram_bus.we) begin
            w = mem[ram_bus.wa];
            for (int i = 0; i < 4; i++)
                if (ram_bus.be[i] || ram_mode == 3) w[i*8 +: 8] = ram_bus.wd[i*8 +: 8];
            mem[ram_bus.wa] <= w;
        end
        w = mem[ram_bus.ra];
        if (ram_bus.ra == 4'd5 && ram_mode == 1) w[9] = 1'b1;
        if (ram_bus.ra == 4'd5 && ram_mode == 2) w[9] = 1'b0;
        rd_q <= w;
    end

    int          wr_n, rd_n;
    bit          ra_seen;
    logic [3:0]  last_ra;
    logic [3:0]  log_be [2][16];
    logic [31:0] log_wd [2][16];

    always @(negedge clk) begin
        int ph;
        if (!rst) begin
            if (ram_bus.we) begin
                ph = (wr_n < 16) ? 0 : 1;
                log_be[ph][ram_bus.wa] = ram_bus.be;
                log_wd[ph][ram_bus.wa] = ram_bus.wd;
                wr_n++;
            end else if (busy && wr_n == 32 && (!ra_seen || ram_bus.ra != last_ra)) begin
                rd_n++;
                ra_seen = 1'b1;
                last_ra = ram_bus.ra;
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns the edge number (start edge = 0) after which done reads 1, or -1.
    task automatic run_test(input bit hold, output int cyc);
        bit seen;
        wr_n = 0; rd_n = 0; ra_seen = 1'b0;
        start = 1'b1;
        @(posedge clk);
        cyc = 0;
        seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            cyc++;
        end
        if (!seen) cyc = -1;
    endtask

    typedef struct {
        int         mode;
        logic       exp_fail;
        logic [3:0] exp_addr;
        int         exp_err;
    } scen_t;

    typedef struct {
        int          ph;
        int          addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
    } wlog_t;

    scen_t scen [4];
    wlog_t wlog [6];

    initial begin
        int  cyc;
        bit  found;
        // bit 9 of E(5)=32'h0807F905 is already 0, so only stuck-at-1 there is visible
        scen[0] = '{0, 1'b0, 4'd0, 0};
        scen[1] = '{1, 1'b1, 4'd5, 1};
        scen[2] = '{2, 1'b0, 4'd0, 0};
        scen[3] = '{3, 1'b1, 4'd0, 16};

        wlog[0] = '{0, 0,  4'b1111, 32'h03020100};
        wlog[1] = '{0, 15, 4'b1111, 32'h1211100F};
        wlog[2] = '{1, 6,  4'b0100, 32'hF6F7F8F9};
        wlog[3] = '{1, 0,  4'b0001, 32'hFCFDFEFF};
        wlog[4] = '{1, 15, 4'b1000, 32'hEDEEEFF0};
        wlog[5] = '{1, 9,  4'b0010, 32'hF3F4F5F6};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_bus", 64'({ram_bus.we, ram_bus.be, ram_bus.wa, ram_bus.wd, ram_bus.ra}), 64'd0);
        check("reset_status", 64'({busy, done, fail, fail_addr, err_count}), 64'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("idle_without_start", 64'({busy, ram_bus.we, done}), 64'd0);

        for (int s = 0; s < 4; s++) begin
            ram_mode = scen[s].mode;
            run_test(1'b0, cyc);
            check($sformatf("s%0d_done_edge", s), 64'(cyc), 64'd50);
            check($sformatf("s%0d_fail", s), 64'(fail), 64'(scen[s].exp_fail));
            check($sformatf("s%0d_fail_addr", s), 64'(fail_addr), 64'(scen[s].exp_addr));
            check($sformatf("s%0d_err_count", s), 64'(err_count), 64'(scen[s].exp_err));
            check($sformatf("s%0d_busy", s), 64'(busy), 64'd0);
            check($sformatf("s%0d_writes", s), 64'(wr_n), 64'd32);
            check($sformatf("s%0d_reads", s), 64'(rd_n), 64'd16);
            if (scen[s].mode == 0)
                for (int j = 0; j < 6; j++) begin
                    check($sformatf("wlog%0d_be", j), 64'(log_be[wlog[j].ph][wlog[j].addr]), 64'(wlog[j].exp_be));
                    check($sformatf("wlog%0d_wd", j), 64'(log_wd[wlog[j].ph][wlog[j].addr]), 64'(wlog[j].exp_wd));
                end
        end

        repeat (5) @(negedge clk);
        check("results_held", 64'({done, busy, fail, fail_addr, err_count, ram_bus.we}),
              64'({1'b1, 1'b0, 1'b1, 4'd0, 16'd16, 1'b0}));

        // start held high: one run, restart on the edge after done rises with results cleared
        ram_mode = 3;
        run_test(1'b1, cyc);
        check("hold_done_edge", 64'(cyc), 64'd50);
        check("hold_first_err", 64'(err_count), 64'd16);
        ram_mode = 0;
        @(negedge clk);
        check("hold_restart", 64'({done, busy, fail, fail_addr, err_count}), 64'({1'b0, 1'b1, 1'b0, 4'd0, 16'd0}));
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (done) begin
                found = 1'b1;
                break;
            end
        end
        check("hold_second_done", 64'(found), 64'd1);
        check("hold_second_clean", 64'({fail, err_count}), 64'd0);

        // reset mid-MASK at address 7
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (ram_bus.we && ram_bus.be != 4'hF && ram_bus.wa == 4'd7) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("mask7_reached", 64'(found), 64'd1);
        check("mask7_be", 64'(ram_bus.be), 64'b1000);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_we", 64'(ram_bus.we), 64'd0);
        check("rst_mid_bus", 64'({ram_bus.be, ram_bus.wa, ram_bus.wd, ram_bus.ra}), 64'd0);
        check("rst_mid_status", 64'({busy, done, fail, fail_addr, err_count}), 64'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_stays_idle", 64'({busy, ram_bus.we}), 64'd0);
        run_test(1'b0, cyc);
        check("after_rst_done_edge", 64'(cyc), 64'd50);
        check("after_rst_clean", 64'({fail, err_count}), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
